// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and digit entry buffer.
//   - key code constants for the edit keys and the blank digit value
//   - scanner state enum
//   - helpers for the debounce counter width and row pattern decode
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP    = 4'hA;
    localparam logic [3:0] KEY_CLR     = 4'hB;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam int DEBOUNCE_CNT_DEFAULT = 20000;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    // Debounce counter must hold the value DEBOUNCE_CNT itself.
    function automatic int deb_cnt_width(input int deb_cnt);
        return $clog2(deb_cnt + 1);
    endfunction

    localparam int DEB_W_DEFAULT = deb_cnt_width(DEBOUNCE_CNT_DEFAULT);

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) ||
               (r == 4'b1011) || (r == 4'b0111);
    endfunction

    // Position of the low row line; only meaningful for a one-cold pattern.
    function automatic logic [1:0] low_index(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scan_entry_buffer.sv
// digit_entry_buffer: 8-digit entry register fed by accepted key events.
//   clk, rst_n  : clock, asynchronous active-low reset
//   key_valid   : one-cycle accept strobe (same edge as the top's key_valid)
//   key_code    : code of the accepted key
//   digits      : [3:0] newest digit .. [31:28] oldest, blank = 4'hF
//   digit_cnt   : number of digits entered, 0..8
module digit_entry_buffer
    import keypad_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] digits,
    output logic [3:0]  digit_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= {8{DIGIT_BLANK}};
            digit_cnt <= 4'd0;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                // Shift in at the newest end; the oldest digit falls off when full.
                digits <= {digits[27:0], key_code};
                if (digit_cnt != 4'd8)
                    digit_cnt <= digit_cnt + 4'd1;
            end else if (key_code == KEY_BKSP) begin
                if (digit_cnt != 4'd0) begin
                    digits    <= {DIGIT_BLANK, digits[31:4]};
                    digit_cnt <= digit_cnt - 4'd1;
                end
            end else if (key_code == KEY_CLR) begin
                digits    <= {8{DIGIT_BLANK}};
                digit_cnt <= 4'd0;
            end
            // Codes C-F are commands for the consumer; buffer untouched.
        end
    end

endmodule

// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 matrix keypad scanner with press/release debounce
// and an 8-digit entry buffer for the seven-segment display driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   row        : keypad rows, active-low, asynchronous to clk
//   col        : column drive, active-low one-hot
//   key_valid  : one-cycle pulse per accepted press
//   key_code   : row_index*4 + col_index of the last accepted key
//   digits     : entry buffer, [3:0] newest .. [31:28] oldest
//   digit_cnt  : number of entered digits, 0..8
module keypad_scan_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] digits,
    output logic [3:0]  digit_cnt
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = deb_cnt_width(DEBOUNCE_CNT);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

    // Two-flop synchronizer; idle (no key) reads as all ones.
    logic [3:0] row_meta;
    logic [3:0] rs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    scan_state_t      state,   state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [DEB_W-1:0] deb_cnt, deb_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [3:0]       pattern, pattern_n;
    logic             accept;
    logic [3:0]       accept_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            div_cnt <= '0;
            deb_cnt <= '0;
            col_idx <= 2'd0;
            pattern <= 4'hF;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            deb_cnt <= deb_n;
            col_idx <= col_idx_n;
            pattern <= pattern_n;
        end
    end

    always_comb begin
        state_n   = state;
        div_n     = div_cnt;
        deb_n     = deb_cnt;
        col_idx_n = col_idx;
        pattern_n = pattern;
        accept    = 1'b0;

        case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    // Multi-key (ghost) patterns are skipped like an idle slot.
                    if (single_low(rs)) begin
                        pattern_n = rs;
                        deb_n     = DEB_ONE;
                        state_n   = DEB_PRESS;
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end

            DEB_PRESS: begin
                if (rs != pattern) begin
                    // Bounce: resume scanning at the following column.
                    state_n   = SCAN;
                    col_idx_n = col_idx + 2'd1;
                    div_n     = '0;
                    deb_n     = '0;
                end else if (deb_cnt == DEB_TARGET) begin
                    accept  = 1'b1;
                    state_n = HELD;
                    deb_n   = '0;
                end else begin
                    deb_n = deb_cnt + DEB_ONE;
                end
            end

            HELD: begin
                // Any further keys are ignored until all rows float high.
                if (rs == 4'hF) begin
                    state_n = DEB_REL;
                    deb_n   = DEB_ONE;
                end
            end

            DEB_REL: begin
                if (rs != 4'hF) begin
                    state_n = HELD;
                    deb_n   = '0;
                end else if (deb_cnt == DEB_TARGET) begin
                    state_n   = SCAN;
                    col_idx_n = 2'd0;
                    div_n     = '0;
                    deb_n     = '0;
                end else begin
                    deb_n = deb_cnt + DEB_ONE;
                end
            end

            default: state_n = SCAN;
        endcase
    end

    assign accept_code = {low_index(pattern), col_idx};
    assign col         = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= accept;
            if (accept)
                key_code <= accept_code;
        end
    end

    // Fed with the accept strobe so the buffer updates on the key_valid edge.
    digit_entry_buffer u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (accept),
        .key_code  (accept_code),
        .digits    (digits),
        .digit_cnt (digit_cnt)
    );

endmodule
